// File: rtl/tdc_pulse_pair_gen.sv
// Start/stop pulse-pair generator for TDC bring-up: emits bursts of pairs with a
// cycle-exact interval and period. Optional interval sweep under TDC_PULSE_GEN_SWEEP_EN.
module tdc_pulse_pair_gen #(
    parameter int CNT_WIDTH          = 16,
    parameter int PULSE_WIDTH_CYCLES = 4,
    parameter int CLOCK_PERIOD_PS    = 10000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_interval,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_count,
    input  logic [CNT_WIDTH-1:0] cfg_step,
    input  logic                 abort,
    output logic                 tdc_start_out,
    output logic                 tdc_stop_out,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_error,
    output logic [CNT_WIDTH-1:0] pair_count,
    output logic [31:0]          expected_ps
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    // One extra bit so interval + pulse width never wraps in the comparisons.
    localparam logic [CNT_WIDTH:0]   PW_EXT = (CNT_WIDTH + 1)'(PULSE_WIDTH_CYCLES);
    localparam logic [31:0]          CLK_PS = 32'(CLOCK_PERIOD_PS);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

    function automatic logic start_at(input logic [CNT_WIDTH-1:0] ph);
        return {1'b0, ph} < PW_EXT;
    endfunction

    function automatic logic stop_at(input logic [CNT_WIDTH-1:0] ph,
                                     input logic [CNT_WIDTH-1:0] iv);
        return ({1'b0, ph} >= {1'b0, iv}) && ({1'b0, ph} < ({1'b0, iv} + PW_EXT));
    endfunction

    function automatic logic cfg_ok(input logic [CNT_WIDTH-1:0] iv,
                                    input logic [CNT_WIDTH-1:0] pd);
        return (iv != '0) && ({1'b0, pd} > ({1'b0, iv} + PW_EXT));
    endfunction

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] ph_q, ph_d;
    logic [CNT_WIDTH-1:0] interval_q, interval_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] pair_count_q, pair_count_d;
    logic                 start_q, start_d;
    logic                 stop_q, stop_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_error_q, cfg_error_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic [31:0]          expected_ps_q, expected_ps_d;

    logic                 accept;
    logic                 accept_ok;
    logic [CNT_WIDTH-1:0] iv_next;
    logic                 sweep_fail;

    assign accept    = (state_q == S_IDLE) && cfg_valid && cfg_ready_q;
    assign accept_ok = accept && cfg_ok(cfg_interval, cfg_period);

`ifdef TDC_PULSE_GEN_SWEEP_EN
    logic [CNT_WIDTH-1:0] step_q, step_d;
    logic [CNT_WIDTH:0]   iv_sum;

    always_comb begin
        step_d = step_q;
        if (accept_ok) begin
            step_d = cfg_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    // The carry bit flags a sweep that would overflow the interval counter.
    assign iv_sum     = {1'b0, interval_q} + {1'b0, step_q};
    assign iv_next    = iv_sum[CNT_WIDTH-1:0];
    assign sweep_fail = iv_sum[CNT_WIDTH] || !cfg_ok(iv_next, period_q);
`else
    logic unused_step;

    assign unused_step = ^cfg_step;
    assign iv_next     = interval_q;
    assign sweep_fail  = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path leaves a latch.
    always_comb begin
        state_d       = state_q;
        ph_d          = ph_q;
        interval_d    = interval_q;
        period_d      = period_q;
        count_d       = count_q;
        pair_count_d  = pair_count_q;
        expected_ps_d = expected_ps_q;
        start_d       = 1'b0;
        stop_d        = 1'b0;
        done_d        = 1'b0;
        cfg_error_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_ok) begin
                    state_d       = S_RUN;
                    interval_d    = cfg_interval;
                    period_d      = cfg_period;
                    count_d       = cfg_count;
                    pair_count_d  = '0;
                    ph_d          = '0;
                    start_d       = start_at('0);
                    stop_d        = stop_at('0, cfg_interval);
                    expected_ps_d = 32'(cfg_interval) * CLK_PS;
                end else if (accept) begin
                    cfg_error_d = 1'b1;
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ph_q == period_q - ONE) begin
                    pair_count_d = pair_count_q + ONE;
                    if ((count_q != '0) && (pair_count_d == count_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (sweep_fail) begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        cfg_error_d = 1'b1;
                    end else begin
                        ph_d          = '0;
                        interval_d    = iv_next;
                        start_d       = start_at('0);
                        stop_d        = stop_at('0, iv_next);
                        expected_ps_d = 32'(iv_next) * CLK_PS;
                    end
                end else begin
                    ph_d    = ph_q + ONE;
                    start_d = start_at(ph_d);
                    stop_d  = stop_at(ph_d, interval_q);
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d == S_RUN);
        cfg_ready_d = (state_d == S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ph_q          <= '0;
            interval_q    <= '0;
            period_q      <= '0;
            count_q       <= '0;
            pair_count_q  <= '0;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_error_q   <= 1'b0;
            cfg_ready_q   <= 1'b1;
            expected_ps_q <= '0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            interval_q    <= interval_d;
            period_q      <= period_d;
            count_q       <= count_d;
            pair_count_q  <= pair_count_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_error_q   <= cfg_error_d;
            cfg_ready_q   <= cfg_ready_d;
            expected_ps_q <= expected_ps_d;
        end
    end

    assign cfg_ready     = cfg_ready_q;
    assign tdc_start_out = start_q;
    assign tdc_stop_out  = stop_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_error     = cfg_error_q;
    assign pair_count    = pair_count_q;
    assign expected_ps   = expected_ps_q;

endmodule
